// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive path with x-PRESCALE oversampling,
// 2-of-3 majority vote at bit centre, start/data/parity/stop frame FSM.
// Ports: CLK, RST (async active-low), RX_IN (idle high, pre-synchronized),
//   PAR_EN / PAR_TYP (0 even, 1 odd), PRESCALE (8/16/32 clocks per bit),
//   P_DATA (held between frames), DATA_VALID / PAR_ERR / STP_ERR pulses.
// Optional: UART_RX_BREAK_DETECT_EN adds BREAK_DET for all-zero frames.
module uart_rx_deserializer #(
   parameter int WIDTH_DATA = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   output logic [WIDTH_DATA-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                  BREAK_DET,
`endif
   output logic                  STP_ERR
);

   localparam int BIT_W = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH_DATA - 1);
   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t r_state;
   state_t w_next;

   // frame configuration, frozen when the start bit is accepted
   logic [PRESCALE_W-1:0] r_ps;
   logic                  r_par_en;
   logic                  r_par_typ;

   logic [PRESCALE_W-1:0] r_edge;
   logic [BIT_W-1:0]      r_bit;
   logic [2:0]            r_smp;
   logic [WIDTH_DATA-1:0] r_shift;
   logic                  r_par_bad;

   logic [WIDTH_DATA-1:0] r_p_data;
   logic                  r_dv;
   logic                  r_pe;
   logic                  r_se;

   logic [PRESCALE_W-1:0] w_half;
   logic [PRESCALE_W-1:0] w_s0;
   logic [PRESCALE_W-1:0] w_s2;
   logic [PRESCALE_W-1:0] w_last;
   logic                  w_eob;
   logic                  w_vote;
   logic                  w_last_bit;
   logic                  w_par_exp;
   logic                  w_stop_bad;
   logic                  w_se;
   logic                  w_idle_ok;

   logic                  w_start;
   logic                  w_shift;
   logic                  w_par_chk;
   logic                  w_fin;

`ifdef UART_RX_BREAK_DETECT_EN
   logic                  r_all_zero;
   logic                  r_brk_wait;
   logic                  r_brk;
   logic                  w_brk;
`endif

   assign w_half = r_ps >> 1;
   assign w_s0   = w_half - ONE;
   assign w_s2   = w_half + ONE;
   assign w_last = r_ps - ONE;

   assign w_eob = (r_state != S_IDLE) && (r_edge == w_last);

   assign w_vote = (r_smp[0] & r_smp[1]) |
                   (r_smp[0] & r_smp[2]) |
                   (r_smp[1] & r_smp[2]);

   assign w_last_bit = (r_bit == LAST_BIT);

   // r_shift holds the complete data word while in PARITY
   assign w_par_exp  = (^r_shift) ^ r_par_typ;
   assign w_stop_bad = ~w_vote;

`ifdef UART_RX_BREAK_DETECT_EN
   // a break is reported instead of a stop error
   assign w_brk     = w_stop_bad & r_all_zero;
   assign w_se      = w_stop_bad & ~w_brk;
   assign w_idle_ok = ~r_brk_wait;
`else
   assign w_se      = w_stop_bad;
   assign w_idle_ok = 1'b1;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The frame-end cycle is spent in IDLE, so a low RX_IN there
   // is counted as edge 0 of the next start bit.
   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_shift   = 1'b0;
      w_par_chk = 1'b0;
      w_fin     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!RX_IN && w_idle_ok) begin
               w_next  = S_START;
               w_start = 1'b1;
            end
         end
         S_START: begin
            if (w_eob) begin
               w_next = w_vote ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_eob) begin
               w_shift = 1'b1;
               if (w_last_bit) begin
                  w_next = r_par_en ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (w_eob) begin
               w_par_chk = 1'b1;
               w_next    = S_STOP;
            end
         end
         S_STOP: begin
            if (w_eob) begin
               w_fin  = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // edge counter, bit counter and frame configuration
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ps      <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_edge    <= '0;
         r_bit     <= '0;
      end else if (w_start) begin
         r_ps      <= PRESCALE;
         r_par_en  <= PAR_EN;
         r_par_typ <= PAR_TYP;
         // the accepting cycle was edge 0
         r_edge    <= ONE;
         r_bit     <= '0;
      end else if (r_state != S_IDLE) begin
         r_edge <= w_eob ? '0 : r_edge + ONE;
         if (w_shift) begin
            r_bit <= r_bit + 1'b1;
         end
      end
   end

   // three samples around the bit centre
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_smp <= '0;
      end else if (r_state != S_IDLE) begin
         if (r_edge == w_s0) begin
            r_smp[0] <= RX_IN;
         end
         if (r_edge == w_half) begin
            r_smp[1] <= RX_IN;
         end
         if (r_edge == w_s2) begin
            r_smp[2] <= RX_IN;
         end
      end
   end

   // LSB arrives first, so shift in from the top
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_shift <= '0;
      end else if (w_shift) begin
         r_shift <= {w_vote, r_shift[WIDTH_DATA-1:1]};
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_bad <= 1'b0;
      end else if (w_start) begin
         r_par_bad <= 1'b0;
      end else if (w_par_chk && (w_vote != w_par_exp)) begin
         r_par_bad <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_p_data <= '0;
         r_dv     <= 1'b0;
         r_pe     <= 1'b0;
         r_se     <= 1'b0;
      end else begin
         r_dv <= 1'b0;
         r_pe <= 1'b0;
         r_se <= 1'b0;
         if (w_fin) begin
            r_pe <= r_par_bad;
            r_se <= w_se;
            if (!r_par_bad && !w_stop_bad) begin
               r_dv     <= 1'b1;
               r_p_data <= r_shift;
            end
         end
      end
   end

`ifdef UART_RX_BREAK_DETECT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_all_zero <= 1'b0;
         r_brk_wait <= 1'b0;
         r_brk      <= 1'b0;
      end else begin
         r_brk <= 1'b0;
         if (w_start) begin
            r_all_zero <= 1'b1;
         end else if ((w_shift || w_par_chk) && w_vote) begin
            r_all_zero <= 1'b0;
         end
         if (w_fin) begin
            r_brk      <= w_brk;
            r_brk_wait <= w_brk;
         end else if ((r_state == S_IDLE) && RX_IN) begin
            r_brk_wait <= 1'b0;
         end
      end
   end

   assign BREAK_DET = r_brk;
`endif

   assign P_DATA     = r_p_data;
   assign DATA_VALID = r_dv;
   assign PAR_ERR    = r_pe;
   assign STP_ERR    = r_se;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames into uart_rx_deserializer with
// hand-computed expected bytes, pulse timing and error flags.
module tb_uart_rx_deserializer;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] PRESCALE;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;
`ifdef UART_RX_BREAK_DETECT_EN
   logic       BREAK_DET;
`endif

   int checks = 0;
   int failures = 0;
   int n_dv = 0;
   int n_pe = 0;
   int n_se = 0;
   int s_dv, s_pe, s_se;
   logic dv_before;

   uart_rx_deserializer #(
      .WIDTH_DATA(8),
      .PRESCALE_W(6)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .PRESCALE  (PRESCALE),
      .P_DATA    (P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_ERR   (PAR_ERR),
`ifdef UART_RX_BREAK_DETECT_EN
      .BREAK_DET (BREAK_DET),
`endif
      .STP_ERR   (STP_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (DATA_VALID) n_dv++;
      if (PAR_ERR) n_pe++;
      if (STP_ERR) n_se++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one frame starting at the current negedge; returns at the
   // frame-end negedge with RX_IN back high. dv_o is DATA_VALID one
   // cycle before frame end. Bit gbit is inverted at edge count gcnt.
   task automatic send(input logic [7:0] d, input logic pen,
                       input logic pbit, input logic stp, input int ps,
                       input int gbit, input int gcnt,
                       output logic dv_o);
      logic bits [0:10];
      logic v;
      int nb;
      nb = 10 + int'(pen);
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      bits[9] = pbit;
      bits[nb-1] = stp;
      dv_o = 1'bx;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < ps; k++) begin
            v = bits[b];
            if (b == gbit && k == gcnt) v = ~v;
            RX_IN = v;
            if (b == nb - 1 && k == ps - 1) dv_o = DATA_VALID;
            @(negedge CLK);
         end
      end
      RX_IN = 1'b1;
   endtask

   task automatic snap();
      @(posedge CLK);
      s_dv = n_dv;
      s_pe = n_pe;
      s_se = n_se;
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b0;
      RX_IN = 1'b1;
      PAR_EN = 1'b0;
      PAR_TYP = 1'b0;
      PRESCALE = 6'd8;
      repeat (3) @(negedge CLK);
      chk("rst_pdata", 32'(P_DATA), 32'h0);
      chk("rst_dv", 32'(DATA_VALID), 32'h0);
      chk("rst_pe", 32'(PAR_ERR), 32'h0);
      chk("rst_se", 32'(STP_ERR), 32'h0);
      RST = 1'b1;
      repeat (4) @(negedge CLK);

      // 0xA5, even parity (4 ones -> 0), PRESCALE 8: 88 cycles
      PRESCALE = 6'd8;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      send(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1, 0, dv_before);
      chk("a5_dv_early", 32'(dv_before), 32'h0);
      chk("a5_dv", 32'(DATA_VALID), 32'h1);
      chk("a5_pdata", 32'(P_DATA), 32'hA5);
      chk("a5_pe", 32'(PAR_ERR), 32'h0);
      chk("a5_se", 32'(STP_ERR), 32'h0);
      @(negedge CLK);
      chk("a5_dv_single", 32'(DATA_VALID), 32'h0);
      repeat (4) @(negedge CLK);

      // 0x3C odd parity with wrong parity bit 0
      PRESCALE = 6'd16;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b1;
      send(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1, 0, dv_before);
      chk("3c_pe", 32'(PAR_ERR), 32'h1);
      chk("3c_dv", 32'(DATA_VALID), 32'h0);
      chk("3c_se", 32'(STP_ERR), 32'h0);
      chk("3c_pdata_hold", 32'(P_DATA), 32'hA5);
      repeat (4) @(negedge CLK);

      // 0x81 with stop bit 0, no parity
      PRESCALE = 6'd32;
      PAR_EN = 1'b0;
      PAR_TYP = 1'b0;
      send(8'h81, 1'b0, 1'b0, 1'b0, 32, -1, 0, dv_before);
      chk("81_se", 32'(STP_ERR), 32'h1);
      chk("81_dv", 32'(DATA_VALID), 32'h0);
      chk("81_pe", 32'(PAR_ERR), 32'h0);
      chk("81_pdata_hold", 32'(P_DATA), 32'hA5);
      repeat (4) @(negedge CLK);

      // 0x81 again, good stop, 1-clock glitch at count 16 of data bit 0
      send(8'h81, 1'b0, 1'b0, 1'b1, 32, 1, 16, dv_before);
      chk("81g_dv", 32'(DATA_VALID), 32'h1);
      chk("81g_pdata", 32'(P_DATA), 32'h81);
      repeat (4) @(negedge CLK);

      // start glitch: low for 3 clocks, then 5 high to finish the bit time
      PRESCALE = 6'd8;
      snap();
      RX_IN = 1'b0;
      repeat (3) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (5) @(negedge CLK);
      @(posedge CLK);
      chk("glitch_no_dv", 32'(n_dv - s_dv), 32'h0);
      chk("glitch_no_pe", 32'(n_pe - s_pe), 32'h0);
      chk("glitch_no_se", 32'(n_se - s_se), 32'h0);
      @(negedge CLK);
      send(8'hC3, 1'b0, 1'b0, 1'b1, 8, -1, 0, dv_before);
      chk("c3_dv", 32'(DATA_VALID), 32'h1);
      chk("c3_pdata", 32'(P_DATA), 32'hC3);
      repeat (4) @(negedge CLK);

      // back-to-back 0x55, 0xAA, no gap
      snap();
      send(8'h55, 1'b0, 1'b0, 1'b1, 8, -1, 0, dv_before);
      chk("b2b1_dv", 32'(DATA_VALID), 32'h1);
      chk("b2b1_pdata", 32'(P_DATA), 32'h55);
      send(8'hAA, 1'b0, 1'b0, 1'b1, 8, -1, 0, dv_before);
      chk("b2b2_dv_early", 32'(dv_before), 32'h0);
      chk("b2b2_dv", 32'(DATA_VALID), 32'h1);
      chk("b2b2_pdata", 32'(P_DATA), 32'hAA);
      repeat (4) @(negedge CLK);
      @(posedge CLK);
      chk("b2b_dv_count", 32'(n_dv - s_dv), 32'h2);
      @(negedge CLK);

      // reset during data bit 4 of 0xF0
      snap();
      RX_IN = 1'b0;
      repeat (8 * 5) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (4) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("midrst_pdata", 32'(P_DATA), 32'h0);
      chk("midrst_dv", 32'(DATA_VALID), 32'h0);
      @(negedge CLK);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (100) @(negedge CLK);
      @(posedge CLK);
      chk("midrst_no_dv", 32'(n_dv - s_dv), 32'h0);
      chk("midrst_no_err", 32'((n_pe - s_pe) + (n_se - s_se)), 32'h0);
      @(negedge CLK);
      send(8'h0F, 1'b0, 1'b0, 1'b1, 8, -1, 0, dv_before);
      chk("0f_dv", 32'(DATA_VALID), 32'h1);
      chk("0f_pdata", 32'(P_DATA), 32'h0F);
      repeat (4) @(negedge CLK);

      // all-zero frame
      send(8'h00, 1'b0, 1'b0, 1'b0, 8, -1, 0, dv_before);
`ifdef UART_RX_BREAK_DETECT_EN
      chk("brk_det", 32'(BREAK_DET), 32'h1);
      chk("brk_no_se", 32'(STP_ERR), 32'h0);
`else
      chk("zero_se", 32'(STP_ERR), 32'h1);
`endif
      chk("zero_dv", 32'(DATA_VALID), 32'h0);
      chk("zero_pdata_hold", 32'(P_DATA), 32'h0F);
      repeat (4) @(negedge CLK);
      send(8'h12, 1'b0, 1'b0, 1'b1, 8, -1, 0, dv_before);
      chk("12_dv", 32'(DATA_VALID), 32'h1);
      chk("12_pdata", 32'(P_DATA), 32'h12);
      repeat (4) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
